// File: rtl/icb_dma_mst.sv
// ============================================================================
//  Module   : icb_dma_mst
//  Purpose  : Single-channel ICB bus master. Copies a block of 32-bit words
//             from a source address range to a destination address range,
//             one read/write pair per word, commanded via valid/ready and
//             finished with a one-cycle done pulse.
//  Options  : ICB_DMA_FILL_EN - when defined, cmd_fill selects a fill mode
//             that writes the latched cmd_pat to every destination word.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module icb_dma_mst #(
    parameter int AW = 32,
    parameter int LW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_src,
    input  logic [AW-1:0] cmd_dst,
    input  logic [LW-1:0] cmd_len,
    input  logic          cmd_fill,
    input  logic [31:0]   cmd_pat,
    input  logic          cmd_abort,
    output logic          busy,
    output logic          done,
    output logic          aborted,
    output logic          icb_rd,
    output logic [AW-1:0] icb_radr,
    input  logic [31:0]   icb_rdat,
    input  logic          icb_rack,
    output logic          icb_wr,
    output logic [AW-1:0] icb_wadr,
    output logic [31:0]   icb_wdat,
    input  logic          icb_wack
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_src;
    logic [AW-1:0] r_dst;
    logic [LW-1:0] r_remaining;
    logic [31:0]   r_data;
    logic          r_abort_req;
    logic          r_aborted;

    logic          w_accept;
    logic          w_abort_now;
    logic          w_fill_cmd;
    logic          w_fill;
    logic [31:0]   w_wdat;

    assign w_accept    = cmd_valid && (r_state == S_IDLE);
    // An abort seen in the acknowledge cycle itself counts as well.
    assign w_abort_now = r_abort_req || cmd_abort;

`ifdef ICB_DMA_FILL_EN
    logic        r_fill;
    logic [31:0] r_pat;

    // Capture fill mode and pattern at command accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fill <= 1'b0;
            r_pat  <= '0;
        end else if (w_accept) begin
            r_fill <= cmd_fill;
            r_pat  <= cmd_pat;
        end
    end

    assign w_fill_cmd = cmd_fill;
    assign w_fill     = r_fill;
    assign w_wdat     = r_fill ? r_pat : r_data;
`else
    logic unused_fill_ports;
    assign unused_fill_ports = ^{cmd_fill, cmd_pat};
    assign w_fill_cmd        = 1'b0;
    assign w_fill            = 1'b0;
    assign w_wdat            = r_data;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next-state logic: one bus transfer per RD/WR visit.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len == '0)   w_state_nxt = S_DONE;
                    else if (w_fill_cmd) w_state_nxt = S_WR;
                    else                 w_state_nxt = S_RD;
                end
            end
            S_RD: begin
                if (icb_rack) w_state_nxt = w_abort_now ? S_DONE : S_WR;
            end
            S_WR: begin
                if (icb_wack) begin
                    if (w_abort_now || (r_remaining == LW'(1))) w_state_nxt = S_DONE;
                    else if (w_fill)                            w_state_nxt = S_WR;
                    else                                        w_state_nxt = S_RD;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: address/count bookkeeping, read data capture, abort flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_src       <= '0;
            r_dst       <= '0;
            r_remaining <= '0;
            r_data      <= '0;
            r_abort_req <= 1'b0;
            r_aborted   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_src       <= cmd_src;
                        r_dst       <= cmd_dst;
                        r_remaining <= cmd_len;
                        r_abort_req <= 1'b0;
                        r_aborted   <= 1'b0;
                    end
                end
                S_RD: begin
                    if (cmd_abort) r_abort_req <= 1'b1;
                    if (icb_rack) begin
                        r_data <= icb_rdat;
                        if (w_abort_now) r_aborted <= 1'b1;
                    end
                end
                S_WR: begin
                    if (cmd_abort) r_abort_req <= 1'b1;
                    if (icb_wack) begin
                        r_src       <= r_src + AW'(4);
                        r_dst       <= r_dst + AW'(4);
                        r_remaining <= r_remaining - LW'(1);
                        if (w_abort_now) r_aborted <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign aborted   = r_aborted;
    assign icb_rd    = (r_state == S_RD);
    assign icb_wr    = (r_state == S_WR);
    assign icb_radr  = r_src;
    assign icb_wadr  = r_dst;
    assign icb_wdat  = w_wdat;

endmodule

`default_nettype wire

// File: tb/tb_icb_dma_mst.sv
// ============================================================================
//  Module   : tb_icb_dma_mst
//  Purpose  : Self-checking bench for icb_dma_mst. A transaction-level model
//             predicts the read/write address sequence, write data, done
//             cycle and abort status; a per-cycle monitor checks the DUT.
//  Options  : ICB_DMA_FILL_EN - enables the fill-mode test case.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_icb_dma_mst;

    localparam int AW = 32;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_src = '0;
    logic [AW-1:0] cmd_dst = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          cmd_fill = 1'b0;
    logic [31:0]   cmd_pat = '0;
    logic          cmd_abort = 1'b0;
    logic          busy, done, aborted;
    logic          icb_rd, icb_wr;
    logic [AW-1:0] icb_radr, icb_wadr;
    logic [31:0]   icb_rdat = '0;
    logic [31:0]   icb_wdat;
    logic          icb_rack = 1'b0;
    logic          icb_wack = 1'b0;

    icb_dma_mst #(.AW(AW), .LW(LW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
        .cmd_fill(cmd_fill), .cmd_pat(cmd_pat), .cmd_abort(cmd_abort),
        .busy(busy), .done(done), .aborted(aborted),
        .icb_rd(icb_rd), .icb_radr(icb_radr), .icb_rdat(icb_rdat), .icb_rack(icb_rack),
        .icb_wr(icb_wr), .icb_wadr(icb_wadr), .icb_wdat(icb_wdat), .icb_wack(icb_wack)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory contents seen by the reads: a fixed function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Slave: acknowledges after 'waits' low-acknowledge cycles.
    int waits = 0;
    int wcnt  = 0;
    always begin
        @(posedge clk);
        #1;
        icb_rack = 1'b0;
        icb_wack = 1'b0;
        icb_rdat = 32'hBAD0_BAD0;
        if (rst && (icb_rd || icb_wr)) begin
            if (wcnt >= waits) begin
                if (icb_rd) begin
                    icb_rack = 1'b1;
                    icb_rdat = mem_word(icb_radr);
                end else begin
                    icb_wack = 1'b1;
                end
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    // Transaction model: expected reads, writes {addr,data}, done cycle.
    logic [31:0] exp_rd[$];
    logic [63:0] exp_wr[$];
    int          exp_done = 0;
    logic        exp_ab   = 1'b0;

    task automatic model_start(input logic [31:0] s, input logic [31:0] d, input int len,
                               input bit fill, input logic [31:0] pat, input int w,
                               input int abort_k);
        int n_xfer = 0;
        exp_rd.delete();
        exp_wr.delete();
        for (int i = 0; i < len; i++) begin
            logic [31:0] sa = s + 32'(4 * i);
            logic [31:0] da = d + 32'(4 * i);
            if (!fill) begin
                exp_rd.push_back(sa);
                n_xfer++;
            end
            if (abort_k != 0 && i == abort_k - 1) break;
            exp_wr.push_back({da, fill ? pat : mem_word(sa)});
            n_xfer++;
        end
        exp_done = 1 + n_xfer * (w + 1);
        exp_ab   = (abort_k != 0);
    endtask

    // Per-cycle monitor.
    int          cyc = 0;
    bit          active = 1'b0;
    bit          done_seen = 1'b0;
    logic        exp_ab_out = 1'b0;
    bit          prev_rd_pend = 1'b0;
    bit          prev_wr_pend = 1'b0;
    int          rd_count = 0;
    int          wr_count = 0;
    int          last_done_cyc = -1;
    logic [31:0] last_wadr = '0;
    logic [31:0] last_wdat = '0;

    // Compare DUT outputs against the model on every cycle out of reset.
    always @(negedge clk) begin
        if (!rst) begin
            active       = 1'b0;
            exp_ab_out   = 1'b0;
            prev_rd_pend = 1'b0;
            prev_wr_pend = 1'b0;
            exp_rd.delete();
            exp_wr.delete();
        end else begin
            cyc++;
            if (active && cyc == exp_done) exp_ab_out = exp_ab;
            chk("rd_wr_exclusive", {63'd0, icb_rd & icb_wr}, 64'd0);
            chk("busy", {63'd0, busy}, {63'd0, active});
            chk("cmd_ready", {63'd0, cmd_ready}, {63'd0, !active});
            chk("done", {63'd0, done}, {63'd0, active && cyc == exp_done});
            chk("aborted", {63'd0, aborted}, {63'd0, exp_ab_out});
            if (prev_rd_pend) chk("rd_held_until_ack", {63'd0, icb_rd}, 64'd1);
            if (prev_wr_pend) chk("wr_held_until_ack", {63'd0, icb_wr}, 64'd1);
            if (icb_rd) begin
                if (exp_rd.size() == 0) begin
                    chk("rd_unexpected", {63'd0, icb_rd}, 64'd0);
                end else begin
                    chk("radr", {32'd0, icb_radr}, {32'd0, exp_rd[0]});
                    if (icb_rack) begin
                        void'(exp_rd.pop_front());
                        rd_count++;
                    end
                end
            end
            if (icb_wr) begin
                if (exp_wr.size() == 0) begin
                    chk("wr_unexpected", {63'd0, icb_wr}, 64'd0);
                end else begin
                    chk("wadr_wdat", {icb_wadr, icb_wdat}, exp_wr[0]);
                    if (icb_wack) begin
                        void'(exp_wr.pop_front());
                        wr_count++;
                        last_wadr = icb_wadr;
                        last_wdat = icb_wdat;
                    end
                end
            end
            prev_rd_pend = icb_rd && !icb_rack;
            prev_wr_pend = icb_wr && !icb_wack;
            if (done) begin
                done_seen     = 1'b1;
                last_done_cyc = cyc;
                chk("reads_left_at_done", 64'(exp_rd.size()), 64'd0);
                chk("writes_left_at_done", 64'(exp_wr.size()), 64'd0);
                active = 1'b0;
            end
            if (cmd_valid && cmd_ready) begin
                cyc        = 0;
                active     = 1'b1;
                exp_ab_out = 1'b0;
            end
        end
    end

    task automatic issue(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                         input logic f, input logic [31:0] p);
        done_seen = 1'b0;
        rd_count  = 0;
        wr_count  = 0;
        @(posedge clk);
        #1;
        cmd_src   = s;
        cmd_dst   = d;
        cmd_len   = l;
        cmd_fill  = f;
        cmd_pat   = p;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int k = 0; k < 400 && !done_seen; k++) @(posedge clk);
        chk({name, "_done_timeout"}, {63'd0, done_seen}, 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst = 1'b0;
        #20;
        chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_aborted", {63'd0, aborted}, 64'd0);
        chk("rst_rd_wr", {62'd0, icb_rd, icb_wr}, 64'd0);
        chk("rst_addrs", {icb_radr, icb_wadr}, 64'd0);
        chk("rst_wdat", {32'd0, icb_wdat}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Copy of 4 words, zero-wait; an abort in IDLE beforehand is ignored.
        waits = 0;
        cmd_abort = 1'b1;
        repeat (2) @(posedge clk);
        #1 cmd_abort = 1'b0;
        model_start(32'h100, 32'h200, 4, 1'b0, 32'h0, 0, 0);
        issue(32'h100, 32'h200, 16'd4, 1'b0, 32'h0);
        wait_done("t1");
        chk("t1_done_cycle", 64'(last_done_cyc), 64'd9);
        chk("t1_writes", 64'(wr_count), 64'd4);
        chk("t1_reads", 64'(rd_count), 64'd4);
        chk("t1_last_wadr", {32'd0, last_wadr}, 64'h20C);
        chk("t1_last_wdat", {32'd0, last_wdat}, 64'h010C_FEF3);
        chk("t1_aborted", {63'd0, aborted}, 64'd0);

        // Two wait cycles on every acknowledge.
        waits = 2;
        model_start(32'h3000, 32'h4000, 3, 1'b0, 32'h0, 2, 0);
        issue(32'h3000, 32'h4000, 16'd3, 1'b0, 32'h0);
        wait_done("t2");
        chk("t2_done_cycle", 64'(last_done_cyc), 64'd19);
        chk("t2_writes", 64'(wr_count), 64'd3);

        // Zero-length command: done in cycle 1, no bus activity.
        waits = 0;
        model_start(32'h10, 32'h20, 0, 1'b0, 32'h0, 0, 0);
        issue(32'h10, 32'h20, 16'd0, 1'b0, 32'h0);
        wait_done("t3");
        chk("t3_done_cycle", 64'(last_done_cyc), 64'd1);
        chk("t3_bus_count", 64'(rd_count + wr_count), 64'd0);

        // Abort during the read of word 2 of 5 (one wait state per transfer).
        waits = 1;
        model_start(32'h800, 32'h900, 5, 1'b0, 32'h0, 1, 2);
        issue(32'h800, 32'h900, 16'd5, 1'b0, 32'h0);
        repeat (4) @(posedge clk);
        #1 cmd_abort = 1'b1;
        @(posedge clk);
        #1 cmd_abort = 1'b0;
        wait_done("t4");
        chk("t4_done_cycle", 64'(last_done_cyc), 64'd7);
        chk("t4_writes", 64'(wr_count), 64'd1);
        chk("t4_reads", 64'(rd_count), 64'd2);
        repeat (3) @(posedge clk);
        #1;
        chk("t4_aborted_held", {63'd0, aborted}, 64'd1);

        waits = 0;
`ifdef ICB_DMA_FILL_EN
        // Fill of 3 words wrapping past the top of the address space.
        model_start(32'h0, 32'hFFFF_FFFC, 3, 1'b1, 32'hA5A5_A5A5, 0, 0);
        issue(32'h0, 32'hFFFF_FFFC, 16'd3, 1'b1, 32'hA5A5_A5A5);
        wait_done("t5");
        chk("t5_done_cycle", 64'(last_done_cyc), 64'd4);
        chk("t5_reads", 64'(rd_count), 64'd0);
        chk("t5_last_wadr", {32'd0, last_wadr}, 64'h4);
        chk("t5_last_wdat", {32'd0, last_wdat}, 64'hA5A5_A5A5);
`else
        // Fill request is ignored without the fill option: plain copy, wrapping.
        model_start(32'h500, 32'hFFFF_FFFC, 3, 1'b0, 32'h0, 0, 0);
        issue(32'h500, 32'hFFFF_FFFC, 16'd3, 1'b1, 32'hA5A5_A5A5);
        wait_done("t5");
        chk("t5_done_cycle", 64'(last_done_cyc), 64'd7);
        chk("t5_reads", 64'(rd_count), 64'd3);
        chk("t5_last_wadr", {32'd0, last_wadr}, 64'h4);
        chk("t5_last_wdat", {32'd0, last_wdat}, 64'h0508_FAF7);
`endif

        // Reset pulse during a write, then a clean command.
        model_start(32'h600, 32'h700, 3, 1'b0, 32'h0, 0, 0);
        issue(32'h600, 32'h700, 16'd3, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        chk("t6_in_wr", {63'd0, icb_wr}, 64'd1);
        rst = 1'b0;
        #1;
        chk("t6_rst_wr_drop", {62'd0, icb_rd, icb_wr}, 64'd0);
        chk("t6_rst_ready_busy", {62'd0, cmd_ready, busy}, 64'd2);
        chk("t6_rst_addrs", {icb_radr, icb_wadr}, 64'd0);
        chk("t6_rst_wdat", {32'd0, icb_wdat}, 64'd0);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        chk("t6_ready_after", {63'd0, cmd_ready}, 64'd1);
        model_start(32'hA00, 32'hB00, 2, 1'b0, 32'h0, 0, 0);
        issue(32'hA00, 32'hB00, 16'd2, 1'b0, 32'h0);
        wait_done("t6");
        chk("t6_done_cycle", 64'(last_done_cyc), 64'd5);
        chk("t6_writes", 64'(wr_count), 64'd2);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
